// File: rtl/trace_pkg.sv
// Shared definitions for the trace decoder: packet types, payload field
// positions, err_sticky bit indices and the burst direction encoding.
package trace_pkg;

  localparam int PAYLOAD_W = 23;
  localparam int WDOG_W    = 16;

  localparam logic [1:0] PKT_ADDR  = 2'b00;
  localparam logic [1:0] PKT_READ  = 2'b01;
  localparam logic [1:0] PKT_WRITE = 2'b10;
  localparam logic [1:0] PKT_TIME  = 2'b11;

  // Data packet layout: {ts5, ublb, data}
  localparam int TS5_HI  = 22;
  localparam int TS5_LO  = 18;
  localparam int UBLB_HI = 17;
  localparam int UBLB_LO = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  localparam int ERR_ORPHAN  = 0;
  localparam int ERR_MIXED   = 1;
  localparam int ERR_OVERRUN = 2;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_READ  = 2'b01,
    DIR_WRITE = 2'b10
  } burst_dir_e;

  function automatic logic is_data(input logic [1:0] pkt_type);
    return (pkt_type == PKT_READ) || (pkt_type == PKT_WRITE);
  endfunction

endpackage

// File: rtl/trace_time_accum.sv
// Absolute timestamp accumulator; time_now is the post-add value so an
// event can capture the time that includes its own delta.
module trace_time_accum
  import trace_pkg::*;
#(
  parameter int TIME_W = 32
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  input  logic                 add_en,
  input  logic [PAYLOAD_W-1:0] delta,
  output logic [TIME_W-1:0]    time_now
);

  logic [TIME_W-1:0] time_acc;
  logic [TIME_W-1:0] delta_ext;

  always_comb begin
    delta_ext = TIME_W'(delta);
    time_now  = add_en ? (time_acc + delta_ext) : time_acc;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) time_acc <= '0;
    else          time_acc <= time_now;
  end

endmodule

// File: rtl/trace_decoder.sv
// Trace packet to bus-event decoder. Optional counters are enabled with
// the TRACE_DECODER_STATS_EN macro.
//
// Handshakes: a packet transfers when pkt_valid && pkt_ready; an event
// transfers when ev_valid && ev_ready. ev_* hold stable while ev_valid is
// high and ev_ready is low; pkt_ready = !ev_valid || ev_ready.
module trace_decoder
  import trace_pkg::*;
#(
  parameter int TIME_W = 32,
  parameter int ADDR_W = 23
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [1:0]           pkt_type,
  input  logic [PAYLOAD_W-1:0] pkt_payload,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 ev_write,
  output logic [ADDR_W-1:0]    ev_addr,
  output logic [15:0]          ev_data,
  output logic [1:0]           ev_ublb,
  output logic [TIME_W-1:0]    ev_time,
  output burst_dir_e           burst_state,
  output logic [2:0]           err_sticky
`ifdef TRACE_DECODER_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_writes,
  output logic [31:0]          stat_orphans
`endif
);

  logic                 accept;
  logic                 data_pkt;
  logic                 pkt_write;
  logic                 load_ev;
  logic                 orphan;
  logic                 stall;
  logic                 wd_hit;
  logic                 dir_mixed;
  logic                 time_add;
  logic [PAYLOAD_W-1:0] time_delta;
  logic [TIME_W-1:0]    time_now;
  logic [ADDR_W-1:0]    burst_base;
  logic [ADDR_W-1:0]    word_idx;
  logic                 have_addr;
  logic [WDOG_W-1:0]    wd_cnt;
  burst_dir_e           burst_next;

  always_comb begin
    pkt_ready  = reset_n && (!ev_valid || ev_ready);
    accept     = pkt_valid && pkt_ready;
    data_pkt   = is_data(pkt_type);
    pkt_write  = (pkt_type == PKT_WRITE);
    load_ev    = accept && data_pkt && have_addr;
    orphan     = accept && data_pkt && !have_addr;
    stall      = pkt_valid && data_pkt && !pkt_ready;
    wd_hit     = stall && (wd_cnt == {WDOG_W{1'b1}});
    time_add   = accept && (data_pkt || (pkt_type == PKT_TIME));
    time_delta = (pkt_type == PKT_TIME) ? pkt_payload
                                        : PAYLOAD_W'(pkt_payload[TS5_HI:TS5_LO]);
  end

  trace_time_accum #(.TIME_W(TIME_W)) u_time (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .add_en   (time_add),
    .delta    (time_delta),
    .time_now (time_now)
  );

  // Burst direction FSM: state register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) burst_state <= DIR_NONE;
    else          burst_state <= burst_next;
  end

  // Burst direction FSM: next state (first word of a burst fixes direction)
  always_comb begin
    burst_next = burst_state;
    if (accept && (pkt_type == PKT_ADDR)) begin
      burst_next = DIR_NONE;
    end else if (load_ev && (burst_state == DIR_NONE)) begin
      burst_next = pkt_write ? DIR_WRITE : DIR_READ;
    end
  end

  // Burst direction FSM: outputs
  always_comb begin
    dir_mixed = 1'b0;
    if (load_ev) begin
      dir_mixed = ((burst_state == DIR_READ) && pkt_write) ||
                  ((burst_state == DIR_WRITE) && !pkt_write);
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      burst_base <= '0;
      word_idx   <= '0;
      have_addr  <= 1'b0;
    end else if (accept && (pkt_type == PKT_ADDR)) begin
      burst_base <= ADDR_W'(pkt_payload);
      word_idx   <= '0;
      have_addr  <= 1'b1;
    end else if (load_ev) begin
      word_idx   <= word_idx + 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid <= 1'b0;
      ev_write <= 1'b0;
      ev_addr  <= '0;
      ev_data  <= '0;
      ev_ublb  <= '0;
      ev_time  <= '0;
    end else begin
      ev_valid <= load_ev || (ev_valid && !ev_ready);
      if (load_ev) begin
        ev_write <= pkt_write;
        ev_addr  <= burst_base + word_idx;
        ev_data  <= pkt_payload[DATA_HI:DATA_LO];
        ev_ublb  <= pkt_payload[UBLB_HI:UBLB_LO];
        ev_time  <= time_now;
      end
    end
  end

  // Stalled-consumer watchdog: counts consecutive unaccepted data-packet cycles
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)    wd_cnt <= '0;
    else if (!stall) wd_cnt <= '0;
    else if (!wd_hit) wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= '0;
    end else begin
      if (orphan)    err_sticky[ERR_ORPHAN]  <= 1'b1;
      if (dir_mixed) err_sticky[ERR_MIXED]   <= 1'b1;
      if (wd_hit)    err_sticky[ERR_OVERRUN] <= 1'b1;
    end
  end

`ifdef TRACE_DECODER_STATS_EN
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads   <= '0;
      stat_writes  <= '0;
      stat_orphans <= '0;
    end else begin
      if (load_ev && !pkt_write && (stat_reads != '1))  stat_reads   <= stat_reads + 1'b1;
      if (load_ev && pkt_write && (stat_writes != '1))  stat_writes  <= stat_writes + 1'b1;
      if (orphan && (stat_orphans != '1))               stat_orphans <= stat_orphans + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_decoder.sv
// Self-checking bench for trace_decoder: directed scenarios plus random
// traffic against a packet-level reference model with an event queue.
module tb_trace_decoder;
  import trace_pkg::*;

  localparam int TIME_W = 32;
  localparam int ADDR_W = 23;
  localparam int EV_W   = 1 + ADDR_W + 16 + 2 + TIME_W;

  logic              mclk = 1'b0;
  logic              reset_n = 1'b0;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic [1:0]        pkt_type = 2'b00;
  logic [22:0]       pkt_payload = '0;
  logic              ev_valid;
  logic              ev_ready = 1'b0;
  logic              ev_write;
  logic [ADDR_W-1:0] ev_addr;
  logic [15:0]       ev_data;
  logic [1:0]        ev_ublb;
  logic [TIME_W-1:0] ev_time;
  burst_dir_e        burst_state;
  logic [2:0]        err_sticky;
`ifdef TRACE_DECODER_STATS_EN
  logic [31:0]       stat_reads;
  logic [31:0]       stat_writes;
  logic [31:0]       stat_orphans;
`endif

  trace_decoder #(.TIME_W(TIME_W), .ADDR_W(ADDR_W)) dut (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_type    (pkt_type),
    .pkt_payload (pkt_payload),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_write    (ev_write),
    .ev_addr     (ev_addr),
    .ev_data     (ev_data),
    .ev_ublb     (ev_ublb),
    .ev_time     (ev_time),
    .burst_state (burst_state),
    .err_sticky  (err_sticky)
`ifdef TRACE_DECODER_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_orphans(stat_orphans)
`endif
  );

  // Clock / reset
  always #5 mclk = ~mclk;

  int vectors = 0;
  int fails   = 0;

  // Reference model: events still owed to the consumer, plus decoder state
  logic [EV_W-1:0]   exp_q[$];
  logic [TIME_W-1:0] m_time;
  logic [ADDR_W-1:0] m_base;
  logic [ADDR_W-1:0] m_idx;
  logic              m_have;
  int                m_dir;
  logic [2:0]        m_err;
  int                m_stall;

  function automatic logic [22:0] dpl(input logic [4:0] ts, input logic [1:0] ub,
                                      input logic [15:0] d);
    return {ts, ub, d};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_time  = '0;
    m_base  = '0;
    m_idx   = '0;
    m_have  = 1'b0;
    m_dir   = 0;
    m_err   = '0;
    m_stall = 0;
  endtask

  task automatic model_accept(input logic [1:0] t, input logic [22:0] p);
    int w_dir;
    logic [ADDR_W-1:0] a;
    case (t)
      2'b00: begin
        m_base = p;
        m_idx  = '0;
        m_have = 1'b1;
        m_dir  = 0;
      end
      2'b11: m_time = m_time + TIME_W'(p);
      default: begin
        m_time = m_time + TIME_W'(p[22:18]);
        if (!m_have) begin
          m_err[0] = 1'b1;
        end else begin
          w_dir = (t == 2'b10) ? 2 : 1;
          if (m_dir == 0) m_dir = w_dir;
          else if (m_dir != w_dir) m_err[1] = 1'b1;
          a = m_base + m_idx;
          exp_q.push_back({(t == 2'b10), a, p[15:0], p[17:16], m_time});
          m_idx = m_idx + 1'b1;
        end
      end
    endcase
  endtask

  // Driver: one clock of stimulus, checked against the model, then the edge
  task automatic run_cycle(input logic v, input logic [1:0] t, input logic [22:0] p,
                           input logic r);
    logic exp_rdy;
    logic exp_vld;
    logic [EV_W-1:0] cur;
    pkt_valid = v;
    pkt_type = t;
    pkt_payload = p;
    ev_ready = r;
    #1;
    exp_vld = (exp_q.size() != 0);
    exp_rdy = !exp_vld || r;
    vectors++;
    if (pkt_ready !== exp_rdy) begin
      fails++;
      $display("FAIL pkt_ready got %b want %b at %0t", pkt_ready, exp_rdy, $time);
    end
    vectors++;
    if (ev_valid !== exp_vld) begin
      fails++;
      $display("FAIL ev_valid got %b want %b at %0t", ev_valid, exp_vld, $time);
    end
    vectors++;
    if (err_sticky !== m_err) begin
      fails++;
      $display("FAIL err_sticky got %b want %b at %0t", err_sticky, m_err, $time);
    end
    if (exp_vld) begin
      cur = {ev_write, ev_addr, ev_data, ev_ublb, ev_time};
      vectors++;
      if (cur !== exp_q[0]) begin
        fails++;
        $display("FAIL ev_fields got %h want %h at %0t", cur, exp_q[0], $time);
      end
    end
    if (v && (t == 2'b01 || t == 2'b10) && !exp_rdy) begin
      m_stall++;
      if (m_stall >= 65536) m_err[2] = 1'b1;
    end else begin
      m_stall = 0;
    end
    if (exp_vld && r) void'(exp_q.pop_front());
    if (v && exp_rdy) model_accept(t, p);
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    pkt_valid = 1'b0;
    ev_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    pkt_valid = 1'b1;
    pkt_type = 2'b01;
    ev_ready = 1'b1;
    reset_n = 1'b0;
    #2;
    vectors++;
    if (pkt_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got %b want 0", pkt_ready);
    end
    vectors++;
    if ({ev_valid, ev_write, ev_addr, ev_data, ev_ublb, ev_time, err_sticky} !== '0) begin
      fails++;
      $display("FAIL reset_state got v=%b a=%h d=%h t=%h e=%b want all 0",
               ev_valid, ev_addr, ev_data, ev_time, err_sticky);
    end
    do_reset();
    run_cycle(1'b0, 2'b00, '0, 1'b0);
  endtask

  task automatic test_burst_read();
    do_reset();
    run_cycle(1'b1, 2'b00, 23'h000100, 1'b1);
    run_cycle(1'b1, 2'b01, dpl(5'd3, 2'b11, 16'hAAAA), 1'b0);
    vectors++;
    if (ev_valid !== 1'b1 || ev_addr !== 23'h000100 || ev_time !== 32'd3 || ev_data !== 16'hAAAA) begin
      fails++;
      $display("FAIL burst_ev0 got v=%b a=%h t=%h d=%h want 1/000100/3/aaaa",
               ev_valid, ev_addr, ev_time, ev_data);
    end
    run_cycle(1'b1, 2'b01, dpl(5'd0, 2'b01, 16'hBBBB), 1'b1);
    vectors++;
    if (ev_valid !== 1'b1 || ev_addr !== 23'h000101 || ev_time !== 32'd3 || ev_ublb !== 2'b01) begin
      fails++;
      $display("FAIL burst_ev1 got v=%b a=%h t=%h u=%b want 1/000101/3/01",
               ev_valid, ev_addr, ev_time, ev_ublb);
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_addr_wrap();
    do_reset();
    run_cycle(1'b1, 2'b11, 23'h400000, 1'b1);
    run_cycle(1'b1, 2'b00, 23'h7FFFFF, 1'b1);
    run_cycle(1'b1, 2'b10, dpl(5'd31, 2'b10, 16'h1234), 1'b1);
    vectors++;
    if (ev_write !== 1'b1 || ev_addr !== 23'h7FFFFF || ev_time !== 32'h0040001F) begin
      fails++;
      $display("FAIL wrap_ev0 got w=%b a=%h t=%h want 1/7fffff/0040001f", ev_write, ev_addr, ev_time);
    end
    run_cycle(1'b1, 2'b10, dpl(5'd0, 2'b11, 16'h5678), 1'b1);
    vectors++;
    if (ev_addr !== 23'h000000) begin
      fails++;
      $display("FAIL wrap_ev1 got a=%h want 000000", ev_addr);
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_orphan();
    do_reset();
    run_cycle(1'b1, 2'b01, dpl(5'd7, 2'b11, 16'hCAFE), 1'b1);
    vectors++;
    if (ev_valid !== 1'b0 || err_sticky !== 3'b001) begin
      fails++;
      $display("FAIL orphan got v=%b e=%b want 0/001", ev_valid, err_sticky);
    end
    run_cycle(1'b1, 2'b00, 23'h000010, 1'b1);
    run_cycle(1'b1, 2'b01, dpl(5'd0, 2'b11, 16'h0001), 1'b1);
    vectors++;
    if (ev_time !== 32'd7) begin
      fails++;
      $display("FAIL orphan_time got %h want 7", ev_time);
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_cycle(1'b1, 2'b00, 23'h000200, 1'b1);
    run_cycle(1'b1, 2'b01, dpl(5'd1, 2'b11, 16'h1111), 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 2'b01, dpl(5'd2, 2'b11, 16'h2222), 1'b0);
      vectors++;
      if (ev_data !== 16'h1111 || ev_addr !== 23'h000200) begin
        fails++;
        $display("FAIL stall_hold got d=%h a=%h want 1111/000200", ev_data, ev_addr);
      end
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 2'b01, dpl(5'd2, 2'b11, 16'h2222 + 16'(i)), 1'b1);
      vectors++;
      if (ev_valid !== 1'b1 || ev_addr !== 23'h000201 + 23'(i) || ev_data !== 16'h2222 + 16'(i)) begin
        fails++;
        $display("FAIL b2b_%0d got v=%b a=%h d=%h", i, ev_valid, ev_addr, ev_data);
      end
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_mixed_dir();
    do_reset();
    run_cycle(1'b1, 2'b00, 23'h000300, 1'b1);
    run_cycle(1'b1, 2'b01, dpl(5'd0, 2'b11, 16'h0A0A), 1'b1);
    run_cycle(1'b1, 2'b10, dpl(5'd0, 2'b11, 16'h0B0B), 1'b1);
    vectors++;
    if (ev_valid !== 1'b1 || ev_write !== 1'b1 || err_sticky !== 3'b010) begin
      fails++;
      $display("FAIL mixed got v=%b w=%b e=%b want 1/1/010", ev_valid, ev_write, err_sticky);
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    run_cycle(1'b1, 2'b00, 23'h000400, 1'b1);
    run_cycle(1'b1, 2'b01, dpl(5'd9, 2'b11, 16'h4444), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ev_valid !== 1'b0 || pkt_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got v=%b r=%b want 0/0", ev_valid, pkt_ready);
    end
    @(posedge mclk);
    #1;
    reset_n = 1'b1;
    model_reset();
    run_cycle(1'b1, 2'b01, dpl(5'd2, 2'b11, 16'h5555), 1'b1);
    vectors++;
    if (ev_valid !== 1'b0 || err_sticky !== 3'b001) begin
      fails++;
      $display("FAIL post_reset_orphan got v=%b e=%b want 0/001", ev_valid, err_sticky);
    end
    run_cycle(1'b1, 2'b00, 23'h000000, 1'b1);
    run_cycle(1'b1, 2'b01, dpl(5'd0, 2'b11, 16'h6666), 1'b1);
    vectors++;
    if (ev_time !== 32'd2) begin
      fails++;
      $display("FAIL post_reset_time got %h want 2", ev_time);
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0]  t;
    logic [22:0] p;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      t = 2'($urandom_range(0, 3));
      p = 23'($urandom);
      if (t == 2'b00 && $urandom_range(0, 3) == 0) p = 23'h7FFFFF - 23'($urandom_range(0, 3));
      if (t == 2'b11 && $urandom_range(0, 1) == 0) p = 23'($urandom_range(0, 255));
      run_cycle($urandom_range(0, 9) < 8, t, p, $urandom_range(0, 9) < 6);
    end
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic test_watchdog();
    do_reset();
    run_cycle(1'b1, 2'b00, 23'h000500, 1'b1);
    run_cycle(1'b1, 2'b10, dpl(5'd0, 2'b11, 16'h7777), 1'b0);
    for (int i = 0; i < 65535; i++) run_cycle(1'b1, 2'b10, dpl(5'd0, 2'b11, 16'h8888), 1'b0);
    vectors++;
    if (err_sticky[2] !== 1'b0) begin
      fails++;
      $display("FAIL wdog_early got %b want 0", err_sticky[2]);
    end
    run_cycle(1'b1, 2'b10, dpl(5'd0, 2'b11, 16'h8888), 1'b0);
    vectors++;
    if (err_sticky[2] !== 1'b1) begin
      fails++;
      $display("FAIL wdog_fire got %b want 1", err_sticky[2]);
    end
    run_cycle(1'b1, 2'b10, dpl(5'd0, 2'b11, 16'h8888), 1'b1);
    run_cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_burst_read();
    test_addr_wrap();
    test_orphan();
    test_back_to_back();
    test_mixed_dir();
    test_reset_midstream();
    test_random();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/trace_decoder.md
TRACE_DECODER -- requirements
Module: trace_decoder

Interface
REQ-001 Parameter: TIME_W, default 32, width of the absolute timestamp accumulator and event time.
REQ-002 Parameter: ADDR_W, default 23, RAM word-address width; equals the trace address payload width.
REQ-003 Port: mclk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: pkt_valid  input  1  trace packet present.
REQ-006 Port: pkt_ready  output  1  decoder accepts packet this cycle.
REQ-007 Port: pkt_type  input  2  00 address, 01 read word, 10 write word, 11 timestamp.
REQ-008 Port: pkt_payload  input  23  address; or {ts5[22:18], ublb[17:16], data[15:0]}; or timestamp delta.
REQ-009 Port: ev_valid  output  1  decoded bus event held.
REQ-010 Port: ev_ready  input  1  downstream consumes event.
REQ-011 Port: ev_write  output  1  1 write, 0 read.
REQ-012 Port: ev_addr  output  ADDR_W  absolute word address of event.
REQ-013 Port: ev_data  output  16  data word.
REQ-014 Port: ev_ublb  output  2  byte lanes, copied from the packet.
REQ-015 Port: ev_time  output  TIME_W  absolute timestamp of event.
REQ-016 Port: err_sticky  output  3  bit0 orphan word, bit1 mixed-direction burst, bit2 event overrun.

Function
REQ-017 A packet transfers when pkt_valid && pkt_ready; pkt_ready = !ev_valid || ev_ready.
REQ-018 Only data packets (01/10) produce events; address and timestamp packets are always absorbed under the pkt_ready rule.
REQ-019 Address packet: burst_base <= payload, word_idx <= 0, burst_dir <= none, have_addr <= 1; time unchanged.
REQ-020 Timestamp packet: time_acc <= time_acc + zero-extended payload, modulo 2^TIME_W.
REQ-021 Data packet: time_acc += payload[22:18]; the event time is that post-add value.
REQ-022 Data packet: ev_addr = (burst_base + word_idx) mod 2^ADDR_W; word_idx then increments and wraps at 2^ADDR_W.
REQ-023 Event registers load on the accepting cycle; ev_valid rises the next cycle (latency 1) and holds stable until ev_valid && ev_ready.
REQ-024 Simultaneous consume and accept of a new data packet: ev_valid stays 1 and the fields update with no bubble.
REQ-025 Data packet with have_addr=0: set err_sticky[0], advance time, emit no event.
REQ-026 First data word of a burst fixes burst_dir; a later word of the opposite direction sets err_sticky[1] and is still emitted.
REQ-027 err_sticky[2] sets if pkt_valid is held with a data packet for 2^16 consecutive cycles without acceptance (stalled consumer watchdog); the counter clears on any accept.
REQ-028 err_sticky bits clear only on reset.

Reset
REQ-029 Reset clears: ev_valid=0, all ev_* fields 0, time_acc=0, burst_base=0, word_idx=0, have_addr=0, burst_dir=none, err_sticky=0, watchdog=0.
REQ-030 Reset asserted mid-stream discards any held event; the first data word after release without an address is an orphan.
REQ-031 pkt_ready is 0 while reset_n is low.

Configuration
REQ-032 Macro TRACE_DECODER_STATS_EN present: adds outputs stat_reads, stat_writes, stat_orphans (32 bits each, saturating), incremented on the accept cycle, reset to 0.
REQ-033 Macro absent: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-034 Shared package trace_pkg holds the packet-type constants (PKT_ADDR, PKT_READ, PKT_WRITE, PKT_TIME), the payload field bit positions, and the err_sticky bit indices.
REQ-035 A single sub-module, trace_time_accum (time_acc with add-and-wrap), is instantiated once; everything else is flat.

Verification
REQ-036 Addr 0x000100, then read words 0xAAAA/ts5=3 and 0xBBBB/ts5=0 -> events addr 0x100 time 3, then addr 0x101 time 3.
REQ-037 Timestamp 0x400000, then after address 0x7FFFFF write 0x1234/ts5=31 -> ev_addr 0x7FFFFF, time 0x40001F; next write -> ev_addr 0x000000.
REQ-038 Read word before any address -> no ev_valid, err_sticky=3'b001, time advanced by ts5.
REQ-039 ev_ready low for 5 cycles with 3 queued read packets -> pkt_ready low, ev fields stable; back-to-back accepts after release with no bubble.
REQ-040 Address, read, write in one burst -> both events emitted, err_sticky[1]=1.
REQ-041 reset_n pulsed low while ev_valid=1 -> ev_valid=0 asynchronously, time_acc=0, and the next read without an address is flagged orphan.
